// File: rtl/carregador_instrucoes_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package carregador_pkg;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    CARREGANDO = 2'd1,
    CONCLUIDO  = 2'd2
  } estado_t;

  localparam int BYTES_POR_PALAVRA = 4;

  // First byte of the stream lands in the most significant lane.
  localparam bit ORDEM_BIG_ENDIAN = 1'b1;

  function automatic int faixa_lsb(input int indice);
    return ORDEM_BIG_ENDIAN ? (BYTES_POR_PALAVRA - 1 - indice) * 8 : indice * 8;
  endfunction

endpackage

// File: rtl/carregador_instrucoes_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface carregador_instrucoes_if;

  logic [7:0]  byte_dado;
  logic        byte_valido;
  logic        byte_pronto;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_dados;

  modport slave (
    input  byte_dado,
    input  byte_valido,
    output byte_pronto,
    output mem_we,
    output mem_addr,
    output mem_dados
  );

  modport master (
    output byte_dado,
    output byte_valido,
    input  byte_pronto,
    input  mem_we,
    input  mem_addr,
    input  mem_dados
  );

endinterface

// File: rtl/carregador_instrucoes_montador_palavra.sv
// Packs accepted bytes into a 32-bit word; unfilled lanes stay zero so a
// flush yields the zero-padded partial word.
module montador_palavra
  import carregador_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        limpar,
  input  logic        aceitar,
  input  logic        descarregar,
  input  logic [7:0]  byte_dado,
  output logic [31:0] palavra,
  output logic        palavra_completa,
  output logic [1:0]  bytes_parciais
);

  logic [1:0] contador_reg;
  logic       esvaziar;

  assign palavra_completa = aceitar && (contador_reg == 2'(BYTES_POR_PALAVRA - 1));
  assign esvaziar         = limpar || palavra_completa || descarregar;
  assign bytes_parciais   = contador_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || esvaziar) begin
      contador_reg <= 2'd0;
    end else if (aceitar) begin
      contador_reg <= contador_reg + 2'd1;
    end
  end

  // The byte accepted this cycle is forwarded straight into the word so the
  // write port can capture a complete or padded word on the same edge.
  generate
    for (genvar gi = 0; gi < BYTES_POR_PALAVRA; gi++) begin : g_faixa
      localparam logic [1:0] POSICAO = 2'(gi);
      localparam int         LSB     = faixa_lsb(gi);

      logic [7:0] faixa_reg;
      logic       captura;

      assign captura = aceitar && (contador_reg == POSICAO);

      always_ff @(posedge clk) begin
        if (!rst_n || esvaziar) begin
          faixa_reg <= 8'h00;
        end else if (captura) begin
          faixa_reg <= byte_dado;
        end
      end

      assign palavra[LSB +: 8] = captura ? byte_dado : faixa_reg;
    end
  endgenerate

endmodule

// File: rtl/carregador_instrucoes.sv
// Program loader: FSM, word index and instruction-memory write port; keeps the
// CPU in reset until the program is fully written.
module carregador_instrucoes
  import carregador_pkg::*;
#(
  parameter int          NUM_PALAVRAS = 1024,
  parameter logic [31:0] END_BASE     = 32'h0000_0000,
  localparam int         LARGURA_CONT = $clog2(NUM_PALAVRAS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iniciar,
  input  logic                      finalizar,
  carregador_instrucoes_if.slave    bus,
  output logic [LARGURA_CONT-1:0]   palavras_escritas,
  output logic                      cpu_em_reset,
  output logic                      concluido
);

  localparam logic [LARGURA_CONT-1:0] ULTIMO_INDICE = LARGURA_CONT'(NUM_PALAVRAS - 1);

  estado_t                 estado_reg, estado_next;
  logic [LARGURA_CONT-1:0] indice_reg, indice_next;
  logic                    fim_pendente_reg, fim_pendente_next;
  logic                    mem_we_reg, mem_we_next;
  logic [31:0]             mem_addr_reg, mem_addr_next;
  logic [31:0]             mem_dados_reg, mem_dados_next;

  logic        byte_pronto;
  logic        aceitar;
  logic        limpar;
  logic        descarregar;
  logic        escrever;
  logic [31:0] palavra;
  logic        palavra_completa;
  logic [1:0]  bytes_parciais;
  logic [31:0] endereco_atual;

  assign byte_pronto    = (estado_reg == CARREGANDO) && !mem_we_reg && !fim_pendente_reg;
  assign aceitar        = bus.byte_valido && byte_pronto;
  assign endereco_atual = END_BASE + (32'(indice_reg) << 2);

  montador_palavra u_montador (
    .clk              (clk),
    .rst_n            (rst_n),
    .limpar           (limpar),
    .aceitar          (aceitar),
    .descarregar      (descarregar),
    .byte_dado        (bus.byte_dado),
    .palavra          (palavra),
    .palavra_completa (palavra_completa),
    .bytes_parciais   (bytes_parciais)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_reg       <= OCIOSO;
      indice_reg       <= '0;
      fim_pendente_reg <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= END_BASE;
      mem_dados_reg    <= 32'h0000_0000;
    end else begin
      estado_reg       <= estado_next;
      indice_reg       <= indice_next;
      fim_pendente_reg <= fim_pendente_next;
      mem_we_reg       <= mem_we_next;
      mem_addr_reg     <= mem_addr_next;
      mem_dados_reg    <= mem_dados_next;
    end
  end

  always_comb begin
    estado_next       = estado_reg;
    indice_next       = indice_reg;
    fim_pendente_next = fim_pendente_reg;
    mem_we_next       = 1'b0;
    mem_addr_next     = mem_addr_reg;
    mem_dados_next    = mem_dados_reg;
    limpar            = 1'b0;
    descarregar       = 1'b0;
    escrever          = 1'b0;

    case (estado_reg)
      OCIOSO, CONCLUIDO: begin
        if (iniciar) begin
          estado_next       = CARREGANDO;
          indice_next       = '0;
          fim_pendente_next = 1'b0;
          limpar            = 1'b1;
        end
      end

      CARREGANDO: begin
        if (mem_we_reg) begin
          // Write cycle: count the word, then stop if it was the last one.
          indice_next       = indice_reg + LARGURA_CONT'(1);
          fim_pendente_next = 1'b0;
          if (fim_pendente_reg || finalizar || (indice_reg == ULTIMO_INDICE)) begin
            estado_next = CONCLUIDO;
          end
        end else begin
          descarregar = finalizar && ((bytes_parciais != 2'd0) || aceitar);
          escrever    = palavra_completa || descarregar;
          if (escrever) begin
            mem_we_next    = 1'b1;
            mem_addr_next  = endereco_atual;
            mem_dados_next = palavra;
          end
          if (finalizar) begin
            if (escrever) begin
              fim_pendente_next = 1'b1;
            end else begin
              estado_next = CONCLUIDO;
            end
          end
        end
      end

      default: estado_next = OCIOSO;
    endcase
  end

  assign bus.byte_pronto = byte_pronto;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_dados   = mem_dados_reg;

  assign palavras_escritas = indice_reg;
  assign cpu_em_reset      = (estado_reg != CONCLUIDO);
  assign concluido         = (estado_reg == CONCLUIDO);

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Scoreboard bench for the program loader: expected writes are queued as bytes
// are accepted and popped by a monitor on each mem_we.
module tb_carregador_instrucoes;

  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dados;
  } escrita_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iniciar, finalizar, iniciar_p, finalizar_p;
  logic [10:0] palavras;
  logic        cpu_em_reset, concluido;
  logic [1:0]  palavras_p;
  logic        cpu_em_reset_p, concluido_p;

  carregador_instrucoes_if bus ();
  carregador_instrucoes_if bus_p ();

  carregador_instrucoes #(.NUM_PALAVRAS(1024), .END_BASE(BASE)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .iniciar           (iniciar),
    .finalizar         (finalizar),
    .bus               (bus),
    .palavras_escritas (palavras),
    .cpu_em_reset      (cpu_em_reset),
    .concluido         (concluido)
  );

  carregador_instrucoes #(.NUM_PALAVRAS(2), .END_BASE(BASE)) dut_p (
    .clk               (clk),
    .rst_n             (rst_n),
    .iniciar           (iniciar_p),
    .finalizar         (finalizar_p),
    .bus               (bus_p),
    .palavras_escritas (palavras_p),
    .cpu_em_reset      (cpu_em_reset_p),
    .concluido         (concluido_p)
  );

  escrita_t fila[$];
  escrita_t fila_p[$];
  escrita_t e_mon, e_mon_p;
  int checks = 0;
  int errors = 0;

  int unsigned modelo_idx, modelo_n;
  logic [31:0] modelo_palavra;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (fila.size() == 0) begin
        errors++;
        $display("FAIL escrita_inesperada addr=%h dados=%h esperado=nenhuma", bus.mem_addr, bus.mem_dados);
      end else begin
        e_mon = fila.pop_front();
        if (bus.mem_addr !== e_mon.addr || bus.mem_dados !== e_mon.dados) begin
          errors++;
          $display("FAIL escrita addr=%h dados=%h esperado addr=%h dados=%h",
                   bus.mem_addr, bus.mem_dados, e_mon.addr, e_mon.dados);
        end else begin
          $display("escrita addr=%h dados=%h ok", bus.mem_addr, bus.mem_dados);
        end
      end
      checks++;
      if (bus.byte_pronto !== 1'b0) begin
        errors++;
        $display("FAIL pronto_na_escrita obtido=%b esperado=0", bus.byte_pronto);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_p.mem_we === 1'b1) begin
      checks++;
      if (fila_p.size() == 0) begin
        errors++;
        $display("FAIL escrita_inesperada_p addr=%h dados=%h esperado=nenhuma", bus_p.mem_addr, bus_p.mem_dados);
      end else begin
        e_mon_p = fila_p.pop_front();
        if (bus_p.mem_addr !== e_mon_p.addr || bus_p.mem_dados !== e_mon_p.dados) begin
          errors++;
          $display("FAIL escrita_p addr=%h dados=%h esperado addr=%h dados=%h",
                   bus_p.mem_addr, bus_p.mem_dados, e_mon_p.addr, e_mon_p.dados);
        end else begin
          $display("escrita_p addr=%h dados=%h ok", bus_p.mem_addr, bus_p.mem_dados);
        end
      end
    end
  end

  task automatic modelo_aceitar(input logic [7:0] b);
    modelo_palavra[31 - 8 * modelo_n -: 8] = b;
    modelo_n++;
    if (modelo_n == 4) begin
      fila.push_back('{addr: BASE + 32'(modelo_idx * 4), dados: modelo_palavra});
      modelo_idx++;
      modelo_n = 0;
      modelo_palavra = 32'h0;
    end
  endtask

  task automatic modelo_finalizar();
    if (modelo_n != 0) begin
      fila.push_back('{addr: BASE + 32'(modelo_idx * 4), dados: modelo_palavra});
      modelo_idx++;
    end
    modelo_n = 0;
    modelo_palavra = 32'h0;
  endtask

  task automatic aplicar_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    iniciar = 1'b0; finalizar = 1'b0; iniciar_p = 1'b0; finalizar_p = 1'b0;
    bus.byte_valido = 1'b0; bus.byte_dado = 8'h00;
    bus_p.byte_valido = 1'b0; bus_p.byte_dado = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fila.delete(); fila_p.delete();
    modelo_idx = 0; modelo_n = 0; modelo_palavra = 32'h0;
  endtask

  task automatic iniciar_carga();
    iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
  endtask

  task automatic enviar_byte(input logic [7:0] b, input int gap);
    bit ok;
    bus.byte_valido = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_dado = b;
    bus.byte_valido = 1'b1;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.byte_pronto === 1'b1) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    bus.byte_valido = 1'b0;
    if (ok) begin
      modelo_aceitar(b);
    end else begin
      checks++; errors++;
      $display("FAIL byte_timeout byte=%h obtido=nao_aceito esperado=aceito", b);
    end
  endtask

  task automatic esperar_fila(input string nome);
    for (int t = 0; t < 20 && fila.size() != 0; t++) @(negedge clk);
    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL %s escritas_pendentes obtido=%0d esperado=0", nome, fila.size());
    end
  endtask

  task automatic esperar_concluido(input string nome);
    for (int t = 0; t < 20 && concluido !== 1'b1; t++) @(negedge clk);
    checks++;
    if (concluido !== 1'b1 || cpu_em_reset !== 1'b0) begin
      errors++;
      $display("FAIL %s concluido obtido=%b/%b esperado=1/0", nome, concluido, cpu_em_reset);
    end else begin
      $display("%s concluido ok", nome);
    end
  endtask

  task automatic checar_valores_reset(input string nome);
    checks++;
    if (bus.byte_pronto !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== BASE ||
        bus.mem_dados !== 32'h0 || palavras !== 11'd0 || cpu_em_reset !== 1'b1 || concluido !== 1'b0) begin
      errors++;
      $display("FAIL %s obtido pronto=%b we=%b addr=%h dados=%h pal=%0d cpu_rst=%b conc=%b esperado 0 0 %h 0 0 1 0",
               nome, bus.byte_pronto, bus.mem_we, bus.mem_addr, bus.mem_dados, palavras,
               cpu_em_reset, concluido, BASE);
    end else begin
      $display("%s valores de reset ok", nome);
    end
  endtask

  task automatic test_reset();
    aplicar_reset();
    @(negedge clk);
    checar_valores_reset("reset");
    checks++;
    if (cpu_em_reset_p !== 1'b1 || palavras_p !== 2'd0 || bus_p.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_p obtido cpu_rst=%b pal=%0d we=%b esperado 1 0 0", cpu_em_reset_p, palavras_p, bus_p.mem_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq = '{8'h20, 8'h08, 8'h00, 8'h05};
    aplicar_reset();
    iniciar_carga();
    for (int i = 0; i < 4; i++) enviar_byte(seq[i], 0);
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_dados !== 32'h2008_0005) begin
      errors++;
      $display("FAIL latencia obtido we=%b addr=%h dados=%h esperado we=1 addr=0 dados=20080005",
               bus.mem_we, bus.mem_addr, bus.mem_dados);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0 || palavras !== 11'd1 || bus.mem_dados !== 32'h2008_0005) begin
      errors++;
      $display("FAIL pos_escrita obtido we=%b pal=%0d dados=%h esperado we=0 pal=1 dados=20080005",
               bus.mem_we, palavras, bus.mem_dados);
    end else begin
      $display("back_to_back palavras=1 ok");
    end
  endtask

  task automatic test_lacunas();
    aplicar_reset();
    iniciar_carga();
    for (int i = 0; i < 12; i++) enviar_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    esperar_fila("lacunas");
    @(negedge clk);
    checks++;
    if (palavras !== 11'd3) begin
      errors++;
      $display("FAIL lacunas_palavras obtido=%0d esperado=3", palavras);
    end
  endtask

  task automatic test_parcial();
    aplicar_reset();
    iniciar_carga();
    enviar_byte(8'hAB, 0);
    enviar_byte(8'hCD, 0);
    finalizar = 1'b1;
    @(posedge clk); #1;
    finalizar = 1'b0;
    modelo_finalizar();
    esperar_concluido("parcial");
    esperar_fila("parcial");
    checks++;
    if (palavras !== 11'd1) begin
      errors++;
      $display("FAIL parcial_palavras obtido=%0d esperado=1", palavras);
    end
  endtask

  task automatic test_reset_meio();
    aplicar_reset();
    iniciar_carga();
    enviar_byte(8'hDE, 0);
    enviar_byte(8'hAD, 0);
    enviar_byte(8'hBE, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checar_valores_reset("reset_meio");
    @(posedge clk); #1;
    rst_n = 1'b1;
    modelo_n = 0; modelo_idx = 0; modelo_palavra = 32'h0;
    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL reset_meio_fila obtido=%0d esperado=0", fila.size());
    end
    iniciar_carga();
    enviar_byte(8'h11, 0);
    enviar_byte(8'h22, 1);
    enviar_byte(8'h33, 0);
    enviar_byte(8'h44, 2);
    esperar_fila("reset_meio");
    @(negedge clk);
    checks++;
    if (palavras !== 11'd1) begin
      errors++;
      $display("FAIL reset_meio_palavras obtido=%0d esperado=1", palavras);
    end
  endtask

  task automatic test_fim_com_byte();
    aplicar_reset();
    iniciar_carga();
    enviar_byte(8'h01, 0);
    enviar_byte(8'h02, 0);
    enviar_byte(8'h03, 0);
    bus.byte_dado = 8'h04;
    bus.byte_valido = 1'b1;
    finalizar = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.byte_pronto !== 1'b1) begin
      errors++;
      $display("FAIL fim_byte_pronto obtido=%b esperado=1", bus.byte_pronto);
    end
    @(posedge clk); #1;
    bus.byte_valido = 1'b0;
    finalizar = 1'b0;
    modelo_aceitar(8'h04);
    modelo_finalizar();
    esperar_concluido("fim_com_byte");
    repeat (3) @(negedge clk);
    esperar_fila("fim_com_byte");
    checks++;
    if (palavras !== 11'd1) begin
      errors++;
      $display("FAIL fim_byte_palavras obtido=%0d esperado=1", palavras);
    end
  endtask

  task automatic test_capacidade();
    int aceitos;
    int np;
    int idx;
    bit ok;
    logic [7:0] b;
    logic [31:0] pal;
    aplicar_reset();
    iniciar_p = 1'b1;
    @(posedge clk); #1;
    iniciar_p = 1'b0;
    aceitos = 0; np = 0; idx = 0; pal = 32'h0;
    for (int i = 0; i < 12; i++) begin
      b = 8'(8'h30 + i);
      bus_p.byte_dado = b;
      bus_p.byte_valido = 1'b1;
      ok = 0;
      for (int t = 0; t < 8 && !ok; t++) begin
        @(negedge clk);
        if (bus_p.byte_pronto === 1'b1) begin
          @(posedge clk); #1;
          ok = 1;
        end
      end
      bus_p.byte_valido = 1'b0;
      if (ok) begin
        aceitos++;
        pal[31 - 8 * np -: 8] = b;
        np++;
        if (np == 4) begin
          fila_p.push_back('{addr: BASE + 32'(idx * 4), dados: pal});
          idx++; np = 0; pal = 32'h0;
        end
      end
      if (i >= 8) begin
        checks++;
        if (ok) begin
          errors++;
          $display("FAIL byte_apos_limite byte=%0d obtido=aceito esperado=recusado", i + 1);
        end
      end
    end
    checks++;
    if (aceitos != 8) begin
      errors++;
      $display("FAIL capacidade_aceitos obtido=%0d esperado=8", aceitos);
    end
    checks++;
    if (fila_p.size() != 0 || concluido_p !== 1'b1 || cpu_em_reset_p !== 1'b0 || palavras_p !== 2'd2) begin
      errors++;
      $display("FAIL capacidade_fim obtido pend=%0d conc=%b cpu_rst=%b pal=%0d esperado 0 1 0 2",
               fila_p.size(), concluido_p, cpu_em_reset_p, palavras_p);
    end else begin
      $display("capacidade aceitos=%0d palavras=%0d ok", aceitos, palavras_p);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iniciar = 1'b0; finalizar = 1'b0; iniciar_p = 1'b0; finalizar_p = 1'b0;
    bus.byte_valido = 1'b0; bus.byte_dado = 8'h00;
    bus_p.byte_valido = 1'b0; bus_p.byte_dado = 8'h00;
    modelo_idx = 0; modelo_n = 0; modelo_palavra = 32'h0;
    test_reset();
    test_back_to_back();
    test_lacunas();
    test_parcial();
    test_reset_meio();
    test_fim_com_byte();
    test_capacidade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
